// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for F-D-E-M-WB: scoreboard of in-flight destinations,
// load-use stall, branch flush, mem_busy freeze. Optional counters under HZD_STATS_EN.
module pipe_hazard_ctrl #(
  parameter int  DATA_W    = 32,
  parameter int  REG_AW    = 5,
  parameter int  FWD_DEPTH = 2,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [REG_AW-1:0]             id_rs1,
  input  logic [REG_AW-1:0]             id_rs2,
  input  logic [REG_AW-1:0]             id_rd,
  input  logic                          id_we,
  input  logic                          id_is_load,
  input  logic                          ex_branch_taken,
  input  logic                          mem_busy,
  input  logic [DATA_W-1:0]             ex_rd1,
  input  logic [DATA_W-1:0]             ex_rd2,
  input  logic [FWD_DEPTH*DATA_W-1:0]   fwd_data,
  output logic [DATA_W-1:0]             src_a,
  output logic [DATA_W-1:0]             src_b,
  output logic [SEL_W-1:0]              fwd_a_sel,
  output logic [SEL_W-1:0]              fwd_b_sel,
  output logic                          stall_f,
  output logic                          stall_d,
  output logic                          flush_d,
  output logic                          flush_e,
  output logic [15:0]                   stat_stall,
  output logic [15:0]                   stat_flush
);

  logic              v_r   [0:FWD_DEPTH];
  logic [REG_AW-1:0] rd_r  [0:FWD_DEPTH];
  logic              we_r  [0:FWD_DEPTH];
  logic              ld_r  [0:FWD_DEPTH];
  logic [REG_AW-1:0] rs1_r;
  logic [REG_AW-1:0] rs2_r;

  logic lu_stall_s;
  logic issue_s;

  // Load in EX feeding the Decode instruction; rd!=0 also excludes rs==0 matches
  always_comb begin
    lu_stall_s = id_valid & v_r[0] & ld_r[0] & we_r[0] & (rd_r[0] != {REG_AW{1'b0}}) &
                 ((rd_r[0] == id_rs1) | (rd_r[0] == id_rs2));
    issue_s    = id_valid & ~lu_stall_s & ~ex_branch_taken;
  end

  // Pipeline control; a frozen pipe never flushes or bubbles
  always_comb begin
    stall_f = (lu_stall_s & ~ex_branch_taken) | mem_busy;
    stall_d = (lu_stall_s & ~ex_branch_taken) | mem_busy;
    flush_d = ex_branch_taken & ~mem_busy;
    flush_e = (ex_branch_taken & ~mem_busy) | (lu_stall_s & ~mem_busy);
  end

  // Operand select: scan oldest to youngest so the youngest matching stage wins
  always_comb begin
    fwd_a_sel = {SEL_W{1'b0}};
    fwd_b_sel = {SEL_W{1'b0}};
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      fwd_a_sel = (v_r[k] && we_r[k] && (rd_r[k] == rs1_r) && (rs1_r != {REG_AW{1'b0}}))
                  ? SEL_W'(k) : fwd_a_sel;
      fwd_b_sel = (v_r[k] && we_r[k] && (rd_r[k] == rs2_r) && (rs2_r != {REG_AW{1'b0}}))
                  ? SEL_W'(k) : fwd_b_sel;
    end
  end

  // Operand mux from RF or the selected downstream stage
  always_comb begin
    src_a = ex_rd1;
    src_b = ex_rd2;
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      src_a = (fwd_a_sel == SEL_W'(k)) ? fwd_data[k*DATA_W-1 -: DATA_W] : src_a;
      src_b = (fwd_b_sel == SEL_W'(k)) ? fwd_data[k*DATA_W-1 -: DATA_W] : src_b;
    end
  end

  // Scoreboard shift; holds completely while memory is busy
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        v_r[k]  <= 1'b0;
        rd_r[k] <= {REG_AW{1'b0}};
        we_r[k] <= 1'b0;
        ld_r[k] <= 1'b0;
      end
      rs1_r <= {REG_AW{1'b0}};
      rs2_r <= {REG_AW{1'b0}};
    end else if (!mem_busy) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        v_r[k]  <= v_r[k-1];
        rd_r[k] <= rd_r[k-1];
        we_r[k] <= we_r[k-1];
        ld_r[k] <= ld_r[k-1];
      end
      v_r[0]  <= issue_s;
      rd_r[0] <= issue_s ? id_rd  : {REG_AW{1'b0}};
      we_r[0] <= issue_s ? id_we  : 1'b0;
      ld_r[0] <= issue_s ? id_is_load : 1'b0;
      rs1_r   <= issue_s ? id_rs1 : {REG_AW{1'b0}};
      rs2_r   <= issue_s ? id_rs2 : {REG_AW{1'b0}};
    end
  end

`ifdef HZD_STATS_EN
  logic [15:0] stat_stall_r;
  logic [15:0] stat_flush_r;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_stall_r <= 16'h0000;
      stat_flush_r <= 16'h0000;
    end else begin
      if (stall_d && (stat_stall_r != 16'hFFFF)) stat_stall_r <= stat_stall_r + 16'h0001;
      if (flush_d && (stat_flush_r != 16'hFFFF)) stat_flush_r <= stat_flush_r + 16'h0001;
    end
  end

  assign stat_stall = stat_stall_r;
  assign stat_flush = stat_flush_r;
`else
  assign stat_stall = 16'h0000;
  assign stat_flush = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// against a queue-based pipeline model. Counter saturation is exercised when HZD_STATS_EN is set.
module tb_pipe_hazard_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FD = 2;
  localparam int SW = $clog2(FD + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           id_valid, id_we, id_is_load, ex_branch_taken, mem_busy;
  logic [AW-1:0]  id_rs1, id_rs2, id_rd;
  logic [DW-1:0]  ex_rd1, ex_rd2, src_a, src_b;
  logic [FD*DW-1:0] fwd_data;
  logic [SW-1:0]  fwd_a_sel, fwd_b_sel;
  logic           stall_f, stall_d, flush_d, flush_e;
  logic [15:0]    stat_stall, stat_flush;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  pipe_hazard_ctrl #(.DATA_W(DW), .REG_AW(AW), .FWD_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .fwd_data(fwd_data),
    .src_a(src_a), .src_b(src_b), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .stat_stall(stat_stall), .stat_flush(stat_flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          we;
    logic          ld;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
  } instr_t;

  // In-flight instructions, index 0 = EX, index k = stage k
  instr_t pipe_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic decode(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic we, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_we = we; id_is_load = ld;
  endtask

  task automatic do_reset();
    rst = 1'b0; mem_busy = 1'b0; ex_branch_taken = 1'b0;
    decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    ex_rd1 = 32'hDEAD_0001; ex_rd2 = 32'hDEAD_0002; fwd_data = {32'h2222_2222, 32'h1111_1111};
    do_reset();
    @(negedge clk);
    chk_cnt++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b exp 0000", {stall_f, stall_d, flush_d, flush_e});
    else pass_cnt++;
    chk_cnt++;
    if ({fwd_a_sel, fwd_b_sel} !== {SW{2'b00}} || src_a !== ex_rd1 || src_b !== ex_rd2)
      $display("FAIL reset_fwd: sel %0d/%0d src %h/%h", fwd_a_sel, fwd_b_sel, src_a, src_b);
    else pass_cnt++;
    // reset while a load-use stall is pending drops it
    tick();
    decode(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
    tick();
    decode(1'b1, 5'd7, 5'd3, 5'd8, 1'b1, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if (stall_d !== 1'b1) $display("FAIL reset_pre_stall: got %b exp 1", stall_d);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (stall_d !== 1'b0) $display("FAIL reset_mid_stall: got %b exp 0", stall_d);
    else pass_cnt++;
  endtask

  task automatic test_forward();
    do_reset();
    decode(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    tick();
    decode(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0);
    tick();
    decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if (fwd_a_sel !== 2'd1 || src_a !== 32'h1111_1111 || fwd_b_sel !== 2'd0 || src_b !== ex_rd2)
      $display("FAIL fwd_stage1: sel %0d/%0d src_a %h exp sel 1/0 src_a 11111111", fwd_a_sel, fwd_b_sel, src_a);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    do_reset();
    decode(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
    tick();
    decode(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101)
      $display("FAIL lu_stall: got %b exp 1101", {stall_f, stall_d, flush_d, flush_e});
    else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++;
    if ({stall_d, flush_e} !== 2'b00) $display("FAIL lu_one_bubble: got %b exp 00", {stall_d, flush_e});
    else pass_cnt++;
    tick();
    decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if (fwd_a_sel !== 2'd2 || fwd_b_sel !== 2'd2 || src_a !== 32'h2222_2222 || src_b !== 32'h2222_2222)
      $display("FAIL lu_fwd_stage2: sel %0d/%0d src %h/%h exp 2/2 22222222", fwd_a_sel, fwd_b_sel, src_a, src_b);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    do_reset();
    decode(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
    tick();
    decode(1'b1, 5'd7, 5'd4, 5'd8, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({stall_d, flush_d, flush_e} !== 3'b011)
      $display("FAIL br_over_lu: got %b exp 011", {stall_d, flush_d, flush_e});
    else pass_cnt++;
    tick();
    ex_branch_taken = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({stall_d, flush_e, fwd_a_sel} !== {2'b00, 2'd0})
      $display("FAIL br_bubble: stall %b flush_e %b sel %0d exp 0 0 0", stall_d, flush_e, fwd_a_sel);
    else pass_cnt++;
  endtask

  task automatic test_mem_busy();
    do_reset();
    decode(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    tick();
    decode(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0);
    tick();
    decode(1'b1, 5'd6, 5'd5, 5'd9, 1'b1, 1'b0);
    mem_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      ex_branch_taken = (c == 1);
      @(negedge clk);
      chk_cnt++;
      if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1100 || fwd_a_sel !== 2'd1)
        $display("FAIL busy_freeze c%0d: ctrl %b sel %0d exp 1100 1", c, {stall_f, stall_d, flush_d, flush_e}, fwd_a_sel);
      else pass_cnt++;
      tick();
    end
    mem_busy = 1'b0; ex_branch_taken = 1'b0;
    tick();
    decode(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd2)
      $display("FAIL busy_resume: sel %0d/%0d exp 1/2", fwd_a_sel, fwd_b_sel);
    else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++;
    if ({fwd_a_sel, fwd_b_sel} !== {SW{2'b00}})
      $display("FAIL busy_no_dup: sel %0d/%0d exp 0/0", fwd_a_sel, fwd_b_sel);
    else pass_cnt++;
  endtask

  task automatic test_x0();
    do_reset();
    decode(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    tick();
    decode(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    tick();
    decode(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk_cnt++;
    if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0 || src_a !== ex_rd1)
      $display("FAIL x0_fwd: sel %0d/%0d src_a %h exp 0/0 %h", fwd_a_sel, fwd_b_sel, src_a, ex_rd1);
    else pass_cnt++;
    tick();
    decode(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if ({stall_d, flush_e} !== 2'b00) $display("FAIL x0_no_stall: got %b exp 00", {stall_d, flush_e});
    else pass_cnt++;
  endtask

  task automatic test_random();
    int errs;
    logic lu, br, busy, iss;
    logic [SW-1:0] ea, eb;
    logic [DW-1:0] sa, sb;
    instr_t ni;
    do_reset();
    pipe_q.delete();
    for (int k = 0; k <= FD; k++) pipe_q.push_back('0);
    errs = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      decode(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_busy        = ($urandom_range(0, 7) == 0);
      ex_rd1 = $urandom; ex_rd2 = $urandom; fwd_data = {$urandom, $urandom};
      @(negedge clk);
      br = ex_branch_taken; busy = mem_busy;
      lu = id_valid && pipe_q[0].v && pipe_q[0].ld && pipe_q[0].we && pipe_q[0].rd != 0 &&
           (pipe_q[0].rd == id_rs1 || pipe_q[0].rd == id_rs2);
      ea = 0; eb = 0;
      for (int k = 1; k <= FD; k++) begin
        if (ea == 0 && pipe_q[k].v && pipe_q[k].we && pipe_q[0].rs1 != 0 && pipe_q[k].rd == pipe_q[0].rs1) ea = SW'(k);
        if (eb == 0 && pipe_q[k].v && pipe_q[k].we && pipe_q[0].rs2 != 0 && pipe_q[k].rd == pipe_q[0].rs2) eb = SW'(k);
      end
      sa = (ea == 0) ? ex_rd1 : DW'(fwd_data >> (DW * (ea - 1)));
      sb = (eb == 0) ? ex_rd2 : DW'(fwd_data >> (DW * (eb - 1)));
      chk_cnt++;
      if ({stall_f, stall_d, flush_d, flush_e} !==
          {(lu && !br) || busy, (lu && !br) || busy, br && !busy, (br || lu) && !busy}) begin
        $display("FAIL rnd_ctrl c%0d: got %b lu %b br %b busy %b", cyc, {stall_f, stall_d, flush_d, flush_e}, lu, br, busy);
        errs++;
      end else pass_cnt++;
      chk_cnt++;
      if (fwd_a_sel !== ea || fwd_b_sel !== eb || src_a !== sa || src_b !== sb) begin
        $display("FAIL rnd_fwd c%0d: sel %0d/%0d exp %0d/%0d src %h/%h exp %h/%h",
                 cyc, fwd_a_sel, fwd_b_sel, ea, eb, src_a, src_b, sa, sb);
        errs++;
      end else pass_cnt++;
      iss = id_valid && !lu && !br;
      ni = iss ? '{1'b1, id_rd, id_we, id_is_load, id_rs1, id_rs2} : '0;
      tick();
      if (!busy) begin
        void'(pipe_q.pop_back());
        pipe_q.push_front(ni);
      end
      if (errs > 20) break;
    end
  endtask

  task automatic test_stats();
    do_reset();
`ifdef HZD_STATS_EN
    mem_busy = 1'b1;
    for (int c = 0; c < 70000; c++) @(posedge clk);
    #1;
    mem_busy = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (stat_stall !== 16'hFFFF) $display("FAIL stat_sat: got %h exp FFFF", stat_stall);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (stat_stall !== 16'h0000 || stat_flush !== 16'h0000)
      $display("FAIL stat_clear: got %h/%h exp 0000/0000", stat_stall, stat_flush);
    else pass_cnt++;
`else
    mem_busy = 1'b1; ex_branch_taken = 1'b1;
    tick(); tick();
    mem_busy = 1'b0;
    tick();
    ex_branch_taken = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (stat_stall !== 16'h0000 || stat_flush !== 16'h0000)
      $display("FAIL stat_tied: got %h/%h exp 0000/0000", stat_stall, stat_flush);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_busy();
    test_x0();
    test_random();
    test_stats();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
